// File: rtl/div_issue.sv
// EX-stage issue/collect controller for the iterative divider: latches operands, drives
// start/annul, holds the pipeline stalled until the result returns, then pulses HI/LO write.
module div_issue #(
  parameter int ABORT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_valid_i,
  input  logic        div_signed_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        flush_i,
  input  logic        pipe_stall_i,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic        stallreq_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CW = (ABORT_CYCLES < 2) ? 1 : $clog2(ABORT_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ABORT = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          signed_q, signed_d;
  logic [31:0]   op1_q, op1_d;
  logic [31:0]   op2_q, op2_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          we_q, we_d;

  // Handshake: the divider runs while start=1 and raises ready for the cycle the result is
  // valid; start drops in that same cycle so the divider returns to free. annul=1 cancels it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    signed_d    = signed_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    we_d        = 1'b0;
    div_start_o = 1'b0;
    div_annul_o = 1'b0;
    stallreq_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        stallreq_o = div_valid_i & ~flush_i;
        if (div_valid_i && !flush_i) begin
          signed_d = div_signed_i;
          op1_d    = rs_i;
          op2_d    = rt_i;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        div_start_o = ~div_ready_i & ~flush_i;
        stallreq_o  = ~div_ready_i;
        if (flush_i) begin
          cnt_d   = CW'(ABORT_CYCLES);
          state_d = S_ABORT;
        end else if (div_ready_i) begin
          hi_d    = div_result_i[63:32];
          lo_d    = div_result_i[31:0];
          we_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // The finished instruction may still sit in EX; re-issuing it would divide twice.
        if (flush_i || !(pipe_stall_i && div_valid_i)) begin
          state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        div_annul_o = 1'b1;
        stallreq_o  = div_valid_i;
        cnt_d       = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      we_q     <= we_d;
    end
  end

  assign div_signed_o = signed_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign hilo_we_o    = we_q;

endmodule

// File: tb/tb_div_issue.sv
// Directed bench for div_issue with a small behavioural divider answering start/annul.
module tb_div_issue;

  localparam int LAT = 36;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_valid_i;
  logic        div_signed_i;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic        flush_i;
  logic        pipe_stall_i;
  logic        div_ready_i;
  logic [63:0] div_result_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic        stallreq_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_cmp = 0;
  int n_bad = 0;
  int dv_cnt = 0;
  logic [63:0] exp_q[$];

  div_issue #(.ABORT_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .div_valid_i(div_valid_i), .div_signed_i(div_signed_i),
    .rs_i(rs_i), .rt_i(rt_i),
    .flush_i(flush_i), .pipe_stall_i(pipe_stall_i),
    .div_ready_i(div_ready_i), .div_result_i(div_result_i),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_signed_o(div_signed_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .stallreq_o(stallreq_o), .hilo_we_o(hilo_we_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural divider: result LAT start-cycles after start rises, x/0 gives 0
  function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always @(negedge clk) begin
    if (rst || div_annul_o) begin
      dv_cnt = 0;
      div_ready_i = 1'b0;
    end else if (div_ready_i) begin
      dv_cnt = 0;
      div_ready_i = 1'b0;
    end else if (div_start_o) begin
      dv_cnt++;
      if (dv_cnt == LAT) begin
        div_ready_i  = 1'b1;
        div_result_i = div_model(div_signed_o, div_op1_o, div_op2_o);
      end
    end else begin
      dv_cnt = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide, check operands hold during BUSY, then one write pulse with HI/LO,
  // optionally holding the instruction in EX (pipe_stall_i) for `hold` cycles afterwards.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int hold);
    int n;
    int we_n;
    int st_n;
    bit done;
    logic [63:0] e;
    exp_q.push_back({ehi, elo});
    @(negedge clk);
    div_valid_i = 1'b1; div_signed_i = sgn; rs_i = a; rt_i = b; pipe_stall_i = 1'b0;
    n = 0; we_n = 0; st_n = 0; done = 0;
    while (!done && n < 200) begin
      tick();
      n++;
      if (div_start_o) st_n++;
      if (hilo_we_o) begin
        we_n++;
        done = 1;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        check_eq({tag, ":hi"}, {32'd0, hi_o}, {32'd0, e[63:32]});
        check_eq({tag, ":lo"}, {32'd0, lo_o}, {32'd0, e[31:0]});
        check_eq({tag, ":stall_released"}, {63'd0, stallreq_o}, 64'd0);
      end else begin
        check_eq({tag, ":stall_busy"}, {63'd0, stallreq_o}, 64'd1);
        if (n == 1 || n == LAT) begin
          check_eq({tag, ":op1_hold"}, {32'd0, div_op1_o}, {32'd0, a});
          check_eq({tag, ":op2_hold"}, {32'd0, div_op2_o}, {32'd0, b});
          check_eq({tag, ":sgn_hold"}, {63'd0, div_signed_o}, {63'd0, sgn});
        end
        if (n == 1) begin
          rs_i = ~a; rt_i = ~b; div_signed_i = ~sgn;
        end
      end
    end
    if (!done) check_eq({tag, ":timeout"}, 64'd0, 64'd1);
    if (hold > 0) pipe_stall_i = 1'b1;
    else div_valid_i = 1'b0;
    for (int i = 0; i < hold + 3; i++) begin
      if (i == hold) begin
        pipe_stall_i = 1'b0; div_valid_i = 1'b0;
      end
      tick();
      if (hilo_we_o) we_n++;
      if (div_start_o) st_n++;
      check_eq({tag, ":no_reissue_stall"}, {63'd0, stallreq_o}, 64'd0);
    end
    check_eq({tag, ":we_pulses"}, we_n, 64'd1);
    check_eq({tag, ":start_cycles"}, st_n, LAT);
  endtask

  initial begin
    rst = 1'b1; div_valid_i = 1'b0; div_signed_i = 1'b0; rs_i = '0; rt_i = '0;
    flush_i = 1'b0; pipe_stall_i = 1'b0; div_ready_i = 1'b0; div_result_i = '0;
    tick(); tick();
    check_eq("rst:outs", {div_start_o, div_annul_o, div_signed_o, stallreq_o, hilo_we_o}, 64'd0);
    check_eq("rst:hilo", {hi_o, lo_o}, 64'd0);
    check_eq("rst:ops", {div_op1_o, div_op2_o}, 64'd0);
    @(negedge clk); rst = 1'b0;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_div("divu_x_0", 1'b0, 32'd12345, 32'd0, 32'd0, 32'd0, 0);

    // flush 10 cycles into BUSY
    @(negedge clk);
    div_valid_i = 1'b1; div_signed_i = 1'b0; rs_i = 32'd100; rt_i = 32'd3;
    for (int i = 0; i < 10; i++) tick();
    flush_i = 1'b1; div_valid_i = 1'b0;
    #1;
    check_eq("flush:start_drop", {63'd0, div_start_o}, 64'd0);
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("flush:annul%0d", i), {63'd0, div_annul_o}, (i < 3) ? 64'd1 : 64'd0);
      check_eq($sformatf("flush:no_we%0d", i), {63'd0, hilo_we_o}, 64'd0);
      check_eq($sformatf("flush:no_start%0d", i), {63'd0, div_start_o}, 64'd0);
      tick();
    end
    check_eq("flush:hilo_kept", {hi_o, lo_o}, 64'd0);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 0);

    run_div("stall_hold", 1'b0, 32'd20, 32'd6, 32'd2, 32'd3, 5);

    // reset in the middle of BUSY
    @(negedge clk);
    div_valid_i = 1'b1; div_signed_i = 1'b1; rs_i = 32'd50; rt_i = 32'd5;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; div_valid_i = 1'b0;
    tick();
    check_eq("rst_mid:outs", {div_start_o, div_annul_o, div_signed_o, stallreq_o, hilo_we_o}, 64'd0);
    check_eq("rst_mid:hilo", {hi_o, lo_o}, 64'd0);
    check_eq("rst_mid:ops", {div_op1_o, div_op2_o}, 64'd0);
    @(negedge clk); rst = 1'b0;
    run_div("divu_8_2", 1'b0, 32'd8, 32'd2, 32'd0, 32'd4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
